sound_event_arbiter: RTL and testbench

Shares the single tone generator between game event sources: win, lose, scored and ball collision. Each source raises a level or pulse request, and the arbiter latches it as a pending event. Pending events are granted by fixed priority. For each granted event the arbiter drives the tone select and enable for a duration measured in video frames, then inserts a silent gap. It sits between game_controller_SM (plus the collision unit) and the audio tone generator.

---
 rtl/sound_pkg.sv | 37 +++
 rtl/sound_prio_enc.sv | 23 ++
 rtl/sound_event_arbiter.sv | 140 ++++++++++++++
 tb/tb_sound_event_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types and event tables for the sound event arbiter.
// Tables are indexed by event number; index 0 is the highest priority.
package sound_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    localparam int EV_WIN     = 0;
    localparam int EV_LOSE    = 1;
    localparam int EV_SCORED  = 2;
    localparam int EV_COLLIDE = 3;

    function automatic int tone_lookup(input int ev);
        case (ev)
            EV_WIN:     tone_lookup = 8;
            EV_LOSE:    tone_lookup = 2;
            EV_SCORED:  tone_lookup = 11;
            EV_COLLIDE: tone_lookup = 5;
            default:    tone_lookup = 0;
        endcase
    endfunction

    // Durations are in video frames.
    function automatic int dur_lookup(input int ev);
        case (ev)
            EV_WIN:     dur_lookup = 30;
            EV_LOSE:    dur_lookup = 45;
            EV_SCORED:  dur_lookup = 10;
            EV_COLLIDE: dur_lookup = 3;
            default:    dur_lookup = 1;
        endcase
    endfunction

endpackage

// File: rtl/sound_prio_enc.sv
// Combinational lowest-index-first priority encoder.
// idx_o is zero when no bit is set; qualify it with any_o.
module sound_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
        // Scan downwards so the lowest set index is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

endmodule

// File: rtl/sound_event_arbiter.sv
// Arbitrates game sound events onto one tone generator: edge capture,
// fixed-priority grant, frame-timed play with preemption, then a silent gap.
module sound_event_arbiter
    import sound_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TONE_W     = 4,
    parameter int DUR_W      = 6,
    parameter int GAP_FRAMES = 2,
    localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic [NUM_REQ-1:0] req_in,
    output logic               sound_en,
    output logic [TONE_W-1:0]  tone_sel,
    output logic [ID_W-1:0]    active_id,
    output logic               busy,
    output logic               preempted
);

    logic [NUM_REQ-1:0] req_d_q;
    logic [NUM_REQ-1:0] pending_q;
    logic [NUM_REQ-1:0] pending_d;
    logic [NUM_REQ-1:0] rise;
    logic [NUM_REQ-1:0] clr;
    state_e             state_q;
    logic [DUR_W-1:0]   dur_cnt_q;
    logic [DUR_W-1:0]   gap_cnt_q;
    logic               sound_en_q;
    logic [TONE_W-1:0]  tone_sel_q;
    logic [ID_W-1:0]    active_id_q;
    logic               busy_q;
    logic               preempted_q;

    logic [ID_W-1:0]    win_idx;
    logic               win_any;
    logic               preempt_req;
    logic               grant;
    logic [TONE_W-1:0]  grant_tone;
    logic [DUR_W-1:0]   grant_dur_raw;
    logic [DUR_W-1:0]   grant_dur;

    sound_prio_enc #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_prio_enc (
        .vec_i (pending_q),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    always_comb begin
        rise          = req_in & ~req_d_q;
        preempt_req   = (state_q == S_PLAY) && win_any && (win_idx < active_id_q);
        grant         = ((state_q == S_IDLE) && win_any) || preempt_req;
        clr           = grant ? (NUM_REQ'(1) << win_idx) : '0;
        // An edge arriving on the granted bit in the same cycle survives the clear.
        pending_d     = (pending_q & ~clr) | rise;
        grant_tone    = TONE_W'(tone_lookup(int'(win_idx)));
        grant_dur_raw = DUR_W'(dur_lookup(int'(win_idx)));
        grant_dur     = (grant_dur_raw == '0) ? DUR_W'(1) : grant_dur_raw;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            req_d_q     <= '0;
            pending_q   <= '0;
            state_q     <= S_IDLE;
            dur_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            sound_en_q  <= 1'b0;
            tone_sel_q  <= '0;
            active_id_q <= '0;
            busy_q      <= 1'b0;
            preempted_q <= 1'b0;
        end else begin
            req_d_q     <= req_in;
            pending_q   <= pending_d;
            preempted_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant) begin
                        active_id_q <= win_idx;
                        tone_sel_q  <= grant_tone;
                        dur_cnt_q   <= grant_dur;
                        sound_en_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    // Preemption wins over expiry; the aborted event is dropped.
                    if (preempt_req) begin
                        active_id_q <= win_idx;
                        tone_sel_q  <= grant_tone;
                        dur_cnt_q   <= grant_dur;
                        preempted_q <= 1'b1;
                    end else if (startOfFrame) begin
                        if (dur_cnt_q <= DUR_W'(1)) begin
                            dur_cnt_q  <= '0;
                            sound_en_q <= 1'b0;
                            if (GAP_FRAMES > 0) begin
                                gap_cnt_q <= DUR_W'(GAP_FRAMES);
                                state_q   <= S_GAP;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                        end else begin
                            dur_cnt_q <= dur_cnt_q - DUR_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (startOfFrame) begin
                        if (gap_cnt_q <= DUR_W'(1)) begin
                            gap_cnt_q <= '0;
                            busy_q    <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - DUR_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sound_en  = sound_en_q;
    assign tone_sel  = tone_sel_q;
    assign active_id = active_id_q;
    assign busy      = busy_q;
    assign preempted = preempted_q;

endmodule

// File: tb/tb_sound_event_arbiter.sv
// Directed bench for sound_event_arbiter: a table of single-event plays
// followed by hand-written multi-event, preemption and reset sequences.
module tb_sound_event_arbiter;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic [3:0] req_in = 4'b0;
    logic       sound_en;
    logic [3:0] tone_sel;
    logic [1:0] active_id;
    logic       busy;
    logic       preempted;

    sound_event_arbiter #(
        .NUM_REQ    (4),
        .TONE_W     (4),
        .DUR_W      (6),
        .GAP_FRAMES (2)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .req_in       (req_in),
        .sound_en     (sound_en),
        .tone_sel     (tone_sel),
        .active_id    (active_id),
        .busy         (busy),
        .preempted    (preempted)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int cnt_play [16];
    int first_f  [16];
    int last_f   [16];
    int cnt_gap;
    int frame_no;
    int rise_cnt;
    int pre_cnt;
    logic prev_en;

    typedef struct {
        int idx;
        int tone;
        int dur;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (preempted) pre_cnt++;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 16; i++) begin
            cnt_play[i] = 0;
            first_f[i]  = -1;
            last_f[i]   = -1;
        end
        cnt_gap  = 0;
        frame_no = 0;
        rise_cnt = 0;
        pre_cnt  = 0;
        prev_en  = 1'b0;
    endtask

    // One video frame: sample the outputs, pulse startOfFrame, idle 3 clocks.
    task automatic frame();
        if (sound_en) begin
            cnt_play[tone_sel]++;
            if (first_f[tone_sel] < 0) first_f[tone_sel] = frame_no;
            last_f[tone_sel] = frame_no;
            if (!prev_en) rise_cnt++;
        end else if (busy) begin
            cnt_gap++;
        end
        prev_en = sound_en;
        frame_no++;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic run_frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        tbl[0] = '{idx: 2, tone: 11, dur: 10};
        tbl[1] = '{idx: 0, tone: 8,  dur: 30};
        tbl[2] = '{idx: 1, tone: 2,  dur: 45};
        tbl[3] = '{idx: 3, tone: 5,  dur: 3};

        clear_stats();
        tick();
        tick();
        check("rst_sound_en", sound_en, 0);
        check("rst_tone_sel", tone_sel, 0);
        check("rst_active_id", active_id, 0);
        check("rst_busy", busy, 0);
        check("rst_preempted", preempted, 0);
        resetN = 1'b1;
        tick();
        tick();

        // Single events, one per source.
        for (int v = 0; v < 4; v++) begin
            clear_stats();
            req_in[tbl[v].idx] = 1'b1;
            tick();
            check("lat_n1_off", sound_en, 0);
            tick();
            req_in = 4'b0;
            check("lat_n2_on", sound_en, 1);
            check("vec_tone", tone_sel, tbl[v].tone);
            check("vec_id", active_id, tbl[v].idx);
            check("vec_busy", busy, 1);
            run_frames(tbl[v].dur + 6);
            check("vec_dur", cnt_play[tbl[v].tone], tbl[v].dur);
            check("vec_gap", cnt_gap, 2);
            check("vec_idle", busy, 0);
            $display("[TB] vec %0d: req %0d tone %0d frames %0d gap %0d", v, tbl[v].idx,
                     tbl[v].tone, cnt_play[tbl[v].tone], cnt_gap);
        end

        // Held level: one sound only.
        clear_stats();
        req_in[0] = 1'b1;
        tick();
        tick();
        run_frames(120);
        req_in = 4'b0;
        check("hold_frames", cnt_play[8], 30);
        check("hold_rises", rise_cnt, 1);
        check("hold_gap", cnt_gap, 2);
        check("hold_idle", busy, 0);
        $display("[TB] hold: frames %0d rises %0d", cnt_play[8], rise_cnt);

        // Simultaneous lose + collide edges.
        clear_stats();
        req_in = 4'b1010;
        tick();
        tick();
        req_in = 4'b0;
        check("sim_first_tone", tone_sel, 2);
        check("sim_first_id", active_id, 1);
        run_frames(60);
        check("sim_lose_frames", cnt_play[2], 45);
        check("sim_coll_frames", cnt_play[5], 3);
        check("sim_order", (first_f[5] > last_f[2]) ? 1 : 0, 1);
        check("sim_gap_between", first_f[5] - last_f[2], 3);
        check("sim_gap_total", cnt_gap, 4);
        check("sim_pending", dut.pending_q, 0);
        check("sim_idle", busy, 0);
        $display("[TB] simul: lose %0d collide %0d gaps %0d", cnt_play[2], cnt_play[5], cnt_gap);

        // Win preempts collide.
        clear_stats();
        req_in[3] = 1'b1;
        tick();
        tick();
        req_in = 4'b0;
        check("pre_coll_tone", tone_sel, 5);
        frame();
        req_in[0] = 1'b1;
        tick();
        check("pre_n1_tone", tone_sel, 5);
        check("pre_n1_pulse", preempted, 0);
        tick();
        req_in = 4'b0;
        check("pre_n2_tone", tone_sel, 8);
        check("pre_n2_id", active_id, 0);
        check("pre_n2_pulse", preempted, 1);
        check("pre_n2_sound", sound_en, 1);
        run_frames(40);
        check("pre_pulses", pre_cnt, 1);
        check("pre_win_frames", cnt_play[8], 30);
        check("pre_coll_frames", cnt_play[5], 1);
        check("pre_idle", busy, 0);
        $display("[TB] preempt: pulses %0d win %0d collide %0d", pre_cnt, cnt_play[8], cnt_play[5]);

        // Lower priority arrival does not preempt.
        clear_stats();
        req_in[2] = 1'b1;
        tick();
        tick();
        req_in = 4'b0;
        run_frames(3);
        req_in[3] = 1'b1;
        tick();
        tick();
        req_in = 4'b0;
        check("nopre_tone", tone_sel, 11);
        run_frames(30);
        check("nopre_pulses", pre_cnt, 0);
        check("nopre_scored", cnt_play[11], 10);
        check("nopre_coll", cnt_play[5], 3);
        check("nopre_gap_between", first_f[5] - last_f[11], 3);
        check("nopre_gap_total", cnt_gap, 4);
        $display("[TB] nopreempt: scored %0d collide %0d gaps %0d", cnt_play[11], cnt_play[5], cnt_gap);

        // Asynchronous reset mid-play with lose and scored pending.
        clear_stats();
        req_in[0] = 1'b1;
        tick();
        tick();
        req_in = 4'b0;
        run_frames(2);
        req_in = 4'b0110;
        tick();
        tick();
        req_in = 4'b0;
        check("rst6_pending", dut.pending_q, 6);
        check("rst6_playing", sound_en, 1);
        #3;
        resetN = 1'b0;
        #1;
        check("rst6_sound_en", sound_en, 0);
        check("rst6_tone", tone_sel, 0);
        check("rst6_busy", busy, 0);
        check("rst6_id", active_id, 0);
        check("rst6_pend_clr", dut.pending_q, 0);
        tick();
        tick();
        resetN = 1'b1;
        clear_stats();
        run_frames(10);
        check("rst6_quiet_win", cnt_play[8], 0);
        check("rst6_quiet_lose", cnt_play[2], 0);
        check("rst6_quiet_scored", cnt_play[11], 0);
        check("rst6_quiet_busy", busy, 0);
        req_in[3] = 1'b1;
        tick();
        tick();
        req_in = 4'b0;
        check("rst6_new_sound", sound_en, 1);
        check("rst6_new_tone", tone_sel, 5);
        run_frames(8);
        check("rst6_new_idle", busy, 0);
        $display("[TB] reset: quiet after release, new collide tone %0d frames %0d", 5, cnt_play[5]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
